counter_arbiter: RTL and testbench
==================================

# counter_arbiter

Round-robin arbiter and sequencer that shares one free-running WIDTH-bit counter resource among N_REQ requesters. Each granted request occupies the resource for a fixed LATENCY, then returns the pre-increment counter value to the winning requester (ticket dispenser) and advances the counter by one. Sits in front of the shared counter submodule; it is the only block that ticks it.

## Interface
- N_REQ, default 4: number of requesters, 2..16.
- WIDTH, default 8: counter and result width.
- LATENCY, default 2: cycles grant is held per transaction, 1..15.
- ID_W, derived as clog2(N_REQ): requester index width.

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  system clock, all state updates on its rising edge.
- reset  in  1  synchronous, active-high; overrides all other inputs.
- req  in  N_REQ  level request per requester.
- grant  out  N_REQ  one-hot, high for the whole BUSY phase of the winner.
- busy  out  1  high in BUSY or ACK.
- ack  out  1  single-cycle completion pulse.
- ack_id  out  ID_W  winner index, valid while ack=1, holds last value otherwise.
- ack_value  out  WIDTH  counter value before increment, valid while ack=1.
- count  out  WIDTH  current counter value.

## Operation
- FSM states: IDLE, BUSY, ACK. All outputs are registered or decoded from registered state only; there is no combinational path from req to any output.
- IDLE:
  - If req is nonzero, choose the winner as the first set bit scanning upward from (last+1) mod N_REQ, wrapping around.
  - Register the winner in grant_id, clear the wait counter, go to BUSY.
  - If req is zero, stay in IDLE.
- BUSY:
  - grant = onehot(grant_id).
  - The wait counter increments each cycle; after LATENCY cycles in BUSY, go to ACK.
  - req is ignored during BUSY. A winner that drops req mid-transaction still completes.
- ACK:
  - ack=1, ack_id=grant_id, ack_value=count, grant=0.
  - On exit: count <= count+1 (mod 2^WIDTH, wraps from all-ones to 0), last <= grant_id, go to IDLE.
- Request semantics:
  - Requests are level, not queued.
  - Each ack consumes exactly one transaction.
  - A requester that still holds req in the IDLE cycle after ack is treated as a new request. Round-robin order puts it last.
- Reset:
  - Values: state=IDLE, grant=0, ack=0, ack_id=0, ack_value=0, count=0, last=N_REQ-1 (requester 0 has first priority), wait counter=0.
  - Reset during BUSY or ACK aborts the transaction: no ack, count not incremented.

## Timing
- Request accepted in IDLE at cycle t:
  - grant high on cycles t+1 .. t+LATENCY.
  - ack on cycle t+LATENCY+1.
  - IDLE again and count updated at t+LATENCY+2.
- Throughput: one transaction per LATENCY+2 cycles under continuous request.
- The busy interval is exactly LATENCY+1 cycles.
- grant and ack are never high in the same cycle.
- At most one grant bit is ever set.
- Simultaneous requests in IDLE: exactly one winner, chosen by round-robin from last+1. The others wait and are evaluated again in the next IDLE cycle.
- req asserted during BUSY or ACK: not evaluated until the next IDLE cycle.
- The first request after reset is evaluated in the first cycle with reset=0.

## Test plan
- Reset then single request:
  - Stimulus: LATENCY=2, req=0001 held from cycle 0.
  - Required response: grant=0001 on cycles 1-2; ack=1, ack_id=0, ack_value=0 on cycle 3; count=1 on cycle 4; next grant=0001 on cycle 5.
- Round-robin fairness:
  - Stimulus: req=1111 held continuously.
  - Required response: ack_id sequence 0,1,2,3,0; ack_value 0,1,2,3,4; no requester granted twice before all others are served.
- Priority rotation:
  - Stimulus: after a transaction completes for requester 2, req=1011.
  - Required response: next winner is 3, then 0, then 1.
- Counter wrap:
  - Stimulus: drive 256 transactions with WIDTH=8.
  - Required response: the 256th ack has ack_value=255; count=0 afterwards; the 257th ack has ack_value=0.
- Request drop and late request:
  - Stimulus: winner drops req mid-BUSY; requester 1 raises req during ACK.
  - Required response: the transaction still acks; requester 1 is granted starting 1 cycle after the following IDLE cycle.
- Reset mid-operation:
  - Stimulus: assert reset during the 2nd BUSY cycle with count=5.
  - Required response: no ack is produced; count=0, grant=0, busy=0 the cycle after reset; the next request goes to requester 0 first.

Source files
------------

// File: rtl/counter_arbiter_if.sv
// ---------------------------------------------------------------------------
// counter_arbiter_if
// Request/grant/ticket bundle between the requesters and counter_arbiter.
//
// Handshake: req is a level request per requester. The arbiter answers with
// a one-hot grant that is held for the whole BUSY phase. A single-cycle ack
// then carries ack_id and ack_value, and that ack consumes exactly one
// transaction. A requester still holding req after its ack is counted as a
// new request. Nothing is queued.
//
// Signals:
//   req       requester -> arbiter  N_REQ  level request per requester
//   grant     arbiter -> requester  N_REQ  one-hot grant during BUSY
//   busy      arbiter -> requester  1      high in BUSY or ACK
//   ack       arbiter -> requester  1      single-cycle completion pulse
//   ack_id    arbiter -> requester  ID_W   winner index (holds after ack)
//   ack_value arbiter -> requester  WIDTH  counter value before increment
//   count     arbiter -> requester  WIDTH  current counter value
// ---------------------------------------------------------------------------
interface counter_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
);
   localparam int ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] grant;
   logic             busy;
   logic             ack;
   logic [ID_W-1:0]  ack_id;
   logic [WIDTH-1:0] ack_value;
   logic [WIDTH-1:0] count;

   modport master (output req, input grant, busy, ack, ack_id, ack_value, count);
   modport slave  (input req, output grant, busy, ack, ack_id, ack_value, count);
endinterface

// File: rtl/counter_arbiter.sv
// ---------------------------------------------------------------------------
// counter_arbiter
// Round-robin arbiter that shares one free-running WIDTH-bit counter among
// N_REQ requesters. Each winner holds the resource for LATENCY cycles. It
// then receives the pre-increment counter value as a ticket, and the counter
// advances by one.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high
//   bus          slave modport of counter_arbiter_if (req in; grant, busy,
//                ack, ack_id, ack_value, count out)
//   dbg_state_o  out  current FSM state (IDLE=0, BUSY=1, ACK=2)
//
// Every output is either a register or a decode of registered state, so no
// combinational path runs from req to any output.
// ---------------------------------------------------------------------------
module counter_arbiter #(
   parameter int N_REQ   = 4,
   parameter int WIDTH   = 8,
   parameter int LATENCY = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   counter_arbiter_if.slave      bus,
   output logic [1:0]            dbg_state_o
);
   localparam int ID_W = $clog2(N_REQ);
   localparam logic [3:0]      LAT_M1  = 4'(LATENCY - 1);
   localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_REQ - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_ACK = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [ID_W-1:0]  grant_id_q, grant_id_d;
   logic [ID_W-1:0]  last_q, last_d;
   logic [3:0]       wait_q, wait_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [ID_W-1:0]  ack_id_q, ack_id_d;
   logic [WIDTH-1:0] ack_value_q, ack_value_d;

   // Round-robin pick. Scan upward from last+1 and wrap, so the most recent
   // winner is considered last.
   logic            found;
   logic [ID_W-1:0] win;
   int              idx;

   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(last_q) + k) % N_REQ;
         if (!found && bus.req[idx[ID_W-1:0]]) begin
            found = 1'b1;
            win   = idx[ID_W-1:0];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_id_d  = grant_id_q;
      last_d      = last_q;
      wait_d      = wait_q;
      count_d     = count_q;
      ack_id_d    = ack_id_q;
      ack_value_d = ack_value_q;
      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               grant_id_d = win;
               wait_d     = '0;
               state_d    = S_BUSY;
            end
         end
         S_BUSY: begin
            wait_d = wait_q + 4'd1;
            if (wait_q == LAT_M1) begin
               // Latch the ticket now so that ack_value is a register during ACK.
               ack_id_d    = grant_id_q;
               ack_value_d = count_q;
               state_d     = S_ACK;
            end
         end
         S_ACK: begin
            count_d = count_q + WIDTH'(1);
            last_d  = grant_id_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         grant_id_q  <= '0;
         last_q      <= LAST_RST;
         wait_q      <= '0;
         count_q     <= '0;
         ack_id_q    <= '0;
         ack_value_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_id_q  <= grant_id_d;
         last_q      <= last_d;
         wait_q      <= wait_d;
         count_q     <= count_d;
         ack_id_q    <= ack_id_d;
         ack_value_q <= ack_value_d;
      end
   end

   always_comb begin
      bus.grant = '0;
      if (state_q == S_BUSY) bus.grant[grant_id_q] = 1'b1;
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.ack       = (state_q == S_ACK);
   assign bus.ack_id    = ack_id_q;
   assign bus.ack_value = ack_value_q;
   assign bus.count     = count_q;
   assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_counter_arbiter.sv
// ---------------------------------------------------------------------------
// tb_counter_arbiter
// Bench for counter_arbiter (N_REQ=4, WIDTH=8, LATENCY=2). A vector table
// gives each request pattern and its expected winner. Expected tickets
// {id, value} are queued as each transaction is driven. A negedge monitor
// pops the queue on each ack and also checks the grant/ack invariants.
// Hand-written sequences cover counter wrap, request drop, late requests and
// reset during a transaction.
// ---------------------------------------------------------------------------
module tb_counter_arbiter;
   localparam int N_REQ = 4;
   localparam int WIDTH = 8;
   localparam int LAT   = 2;

   logic       clock;
   logic       reset;
   logic [1:0] dbg_state;

   counter_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

   counter_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .LATENCY(LAT)) dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // Clock and reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Scoreboard
   int         n_vec = 0;
   int         n_err = 0;
   logic [9:0] exp_q[$];
   logic [7:0] exp_count;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      logic [9:0] e;
      if (bus.ack === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("ack_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("ack_id", 32'(bus.ack_id), 32'(e[9:8]));
            check("ack_value", 32'(bus.ack_value), 32'(e[7:0]));
         end
      end
      if (!$onehot0(bus.grant)) check("grant_onehot0", 32'(bus.grant), 32'd0);
      if ((|bus.grant) && bus.ack) check("grant_and_ack", 32'd1, 32'd0);
   end

   // Driver tasks
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      bus.req = '0;
      reset   = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      exp_count = 8'd0;
      check("rst_grant", 32'(bus.grant), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_ack", 32'(bus.ack), 32'd0);
      check("rst_ack_id", 32'(bus.ack_id), 32'd0);
      check("rst_ack_value", 32'(bus.ack_value), 32'd0);
      check("rst_count", 32'(bus.count), 32'd0);
   endtask

   // Called in IDLE. Drives r, expects winner id, and returns in the IDLE
   // cycle after the ack with req still held.
   task automatic run_txn(input logic [3:0] r, input logic [1:0] id);
      logic [3:0] oh;
      oh = 4'b0001 << id;
      bus.req = r;
      exp_q.push_back({id, exp_count});
      for (int i = 0; i < LAT; i++) begin
         tick();
         check("grant", 32'(bus.grant), 32'(oh));
         check("busy_grant", 32'(bus.busy), 32'd1);
      end
      tick();
      check("ack_pulse", 32'(bus.ack), 32'd1);
      check("grant_in_ack", 32'(bus.grant), 32'd0);
      exp_count = exp_count + 8'd1;
      tick();
      check("ack_done", 32'(bus.ack), 32'd0);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("count", 32'(bus.count), 32'(exp_count));
   endtask

   typedef struct {
      bit         rst;
      logic [3:0] req;
      logic [1:0] id;
   } vec_t;

   vec_t tbl[16];

   initial begin
      tbl[0]  = '{1'b1, 4'b0001, 2'd0};
      tbl[1]  = '{1'b0, 4'b0001, 2'd0};
      tbl[2]  = '{1'b1, 4'b1111, 2'd0};
      tbl[3]  = '{1'b0, 4'b1111, 2'd1};
      tbl[4]  = '{1'b0, 4'b1111, 2'd2};
      tbl[5]  = '{1'b0, 4'b1111, 2'd3};
      tbl[6]  = '{1'b0, 4'b1111, 2'd0};
      tbl[7]  = '{1'b0, 4'b0100, 2'd2};
      tbl[8]  = '{1'b0, 4'b1011, 2'd3};
      tbl[9]  = '{1'b0, 4'b1011, 2'd0};
      tbl[10] = '{1'b0, 4'b1011, 2'd1};
      tbl[11] = '{1'b0, 4'b1010, 2'd3};
      tbl[12] = '{1'b0, 4'b0110, 2'd1};
      tbl[13] = '{1'b0, 4'b0110, 2'd2};
      tbl[14] = '{1'b0, 4'b1001, 2'd3};
      tbl[15] = '{1'b0, 4'b1001, 2'd0};

      bus.req   = '0;
      reset     = 1'b1;
      exp_count = 8'd0;

      // Vector table: reset, single request, fairness and rotation.
      for (int i = 0; i < 16; i++) begin
         if (tbl[i].rst) apply_reset();
         if (i >= 7) begin
            bus.req = '0;
            repeat ($urandom_range(0, 2)) tick();
         end
         run_txn(tbl[i].req, tbl[i].id);
      end

      // Counter wrap: the 256th ticket is 255 and the 257th is 0.
      apply_reset();
      for (int i = 0; i < 257; i++) run_txn(4'b0001, 2'd0);

      // Winner drops req mid-BUSY, and requester 1 raises req during ACK.
      bus.req = 4'b0100;
      exp_q.push_back({2'd2, exp_count});
      tick();
      check("drop_grant1", 32'(bus.grant), 32'h4);
      bus.req = '0;
      tick();
      check("drop_grant2", 32'(bus.grant), 32'h4);
      tick();
      check("drop_ack", 32'(bus.ack), 32'd1);
      bus.req = 4'b0010;
      exp_count = exp_count + 8'd1;
      tick();
      check("late_idle_busy", 32'(bus.busy), 32'd0);
      check("late_idle_grant", 32'(bus.grant), 32'd0);
      check("drop_count", 32'(bus.count), 32'(exp_count));
      exp_q.push_back({2'd1, exp_count});
      tick();
      check("late_grant", 32'(bus.grant), 32'h2);
      bus.req = '0;
      tick();
      tick();
      check("late_ack", 32'(bus.ack), 32'd1);
      exp_count = exp_count + 8'd1;
      tick();
      check("late_count", 32'(bus.count), 32'(exp_count));

      // Reset during the second BUSY cycle with count=5 aborts without an ack.
      apply_reset();
      for (int i = 0; i < 5; i++) run_txn(4'b0001, 2'd0);
      bus.req = 4'b0010;
      tick();
      check("abort_grant1", 32'(bus.grant), 32'h2);
      tick();
      check("abort_count5", 32'(bus.count), 32'd5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.req = '0;
      exp_count = 8'd0;
      check("abort_count", 32'(bus.count), 32'd0);
      check("abort_grant", 32'(bus.grant), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_ack", 32'(bus.ack), 32'd0);
      tick();
      check("abort_no_ack", 32'(bus.ack), 32'd0);
      run_txn(4'b1111, 2'd0);
      bus.req = '0;
      repeat (4) tick();

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
